// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - EX operand forwarding with load-use stall detection
// Resolves NREAD operands against NSTAGES producers; holds retired results across stalls.
module fwd_hazard_unit #(
  parameter int NREAD   = 2,
  parameter int NSTAGES = 2,
  parameter int W       = 32,
  parameter int RB      = 5,
  parameter int CW      = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ex_valid,
  input  logic                  ext_stall,
  input  logic [NREAD*RB-1:0]   src_reg,
  input  logic [NREAD*W-1:0]    rf_dat,
  input  logic [NSTAGES-1:0]    prod_valid,
  input  logic [NSTAGES*RB-1:0] prod_reg,
  input  logic [NSTAGES*W-1:0]  prod_data,
  input  logic [NSTAGES-1:0]    prod_is_load,
  input  logic [NSTAGES-1:0]    prod_ready,
  output logic [NREAD*W-1:0]    opnd,
  output logic                  stall,
  output logic                  bubble,
  output logic                  state_o,
  output logic [CW-1:0]         stall_cnt
);

  localparam logic [0:0] ST_RUN       = 1'b0;
  localparam logic [0:0] ST_LOAD_WAIT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [NREAD-1:0] hold_v_q, hold_v_d;
  logic [W-1:0]     hold_d_q [NREAD];
  logic [W-1:0]     hold_d_d [NREAD];
  logic [CW-1:0]    stall_cnt_q, stall_cnt_d;

  logic [NREAD-1:0] hz, hit, cap;
  int               sel [NREAD];
  logic             hazard, held;

  always_comb begin : resolve
    opnd = rf_dat;
    hz   = '0;
    hit  = '0;
    for (int i = 0; i < NREAD; i++) begin
      sel[i] = 0;
      // Descending scan: the last match written is the youngest stage.
      if (src_reg[i*RB +: RB] != '0) begin
        for (int k = NSTAGES - 1; k >= 0; k--) begin
          if (prod_valid[k] && (prod_reg[k*RB +: RB] == src_reg[i*RB +: RB])) begin
            hit[i] = 1'b1;
            sel[i] = k;
          end
        end
      end
      if (src_reg[i*RB +: RB] == '0) begin
        opnd[i*W +: W] = '0;
      end else if (hit[i]) begin
        if (prod_is_load[sel[i]] && !prod_ready[sel[i]]) begin
          hz[i] = 1'b1;
        end else begin
          opnd[i*W +: W] = prod_data[sel[i]*W +: W];
        end
      end else if (hold_v_q[i]) begin
        opnd[i*W +: W] = hold_d_q[i];
      end
    end
  end

  assign hazard    = ex_valid && (|hz) && !RST;
  assign stall     = hazard;
  assign bubble    = hazard && !ext_stall;
  assign held      = (stall || ext_stall) && ex_valid;
  assign state_o   = state_q[0];
  assign stall_cnt = stall_cnt_q;

  always_comb begin : hold_next
    cap      = '0;
    hold_v_d = hold_v_q;
    for (int i = 0; i < NREAD; i++) begin
      hold_d_d[i] = hold_d_q[i];
      cap[i] = held && hit[i] && (sel[i] == NSTAGES - 1) &&
               (!prod_is_load[NSTAGES-1] || prod_ready[NSTAGES-1]);
      if (!held || !ex_valid) hold_v_d[i] = 1'b0;
      if (cap[i]) begin
        hold_v_d[i] = 1'b1;
        hold_d_d[i] = prod_data[(NSTAGES-1)*W +: W];
      end
    end
  end

  always_comb begin : fsm_next
    state_d = state_q;
    case (state_q)
      ST_RUN:       if (hazard)  state_d = ST_LOAD_WAIT;
      ST_LOAD_WAIT: if (!hazard) state_d = ST_RUN;
      default:      state_d = ST_RUN;
    endcase
    stall_cnt_d = stall_cnt_q;
    if (hazard && !ext_stall && (stall_cnt_q != {CW{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_RUN;
      hold_v_q    <= '0;
      stall_cnt_q <= '0;
      for (int i = 0; i < NREAD; i++) hold_d_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      hold_v_q    <= hold_v_d;
      stall_cnt_q <= stall_cnt_d;
      for (int i = 0; i < NREAD; i++) hold_d_q[i] <= hold_d_d[i];
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - directed bench for fwd_hazard_unit
module tb_fwd_hazard_unit;
  localparam int NREAD = 2, NSTAGES = 2, W = 32, RB = 5;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic ex_valid, ext_stall;
  logic [RB-1:0] sreg [NREAD];
  logic [W-1:0]  rf   [NREAD];
  logic [NSTAGES-1:0] pv, pl, pr;
  logic [RB-1:0] preg [NSTAGES];
  logic [W-1:0]  pdat [NSTAGES];

  logic [NREAD*RB-1:0]   src_reg;
  logic [NREAD*W-1:0]    rf_dat;
  logic [NSTAGES*RB-1:0] prod_reg;
  logic [NSTAGES*W-1:0]  prod_data;
  assign src_reg   = {sreg[1], sreg[0]};
  assign rf_dat    = {rf[1], rf[0]};
  assign prod_reg  = {preg[1], preg[0]};
  assign prod_data = {pdat[1], pdat[0]};

  logic [NREAD*W-1:0] opnd, opnd_s;
  logic stall, bubble, state_o, stall_s, bubble_s, state_s;
  logic [15:0] stall_cnt;
  logic [3:0]  cnt_s;

  fwd_hazard_unit #(.NREAD(NREAD), .NSTAGES(NSTAGES), .W(W), .RB(RB), .CW(16)) dut (
    .CLK(CLK), .RST(RST), .ex_valid(ex_valid), .ext_stall(ext_stall),
    .src_reg(src_reg), .rf_dat(rf_dat), .prod_valid(pv), .prod_reg(prod_reg),
    .prod_data(prod_data), .prod_is_load(pl), .prod_ready(pr),
    .opnd(opnd), .stall(stall), .bubble(bubble), .state_o(state_o), .stall_cnt(stall_cnt)
  );

  fwd_hazard_unit #(.NREAD(NREAD), .NSTAGES(NSTAGES), .W(W), .RB(RB), .CW(4)) dut_sat (
    .CLK(CLK), .RST(RST), .ex_valid(ex_valid), .ext_stall(ext_stall),
    .src_reg(src_reg), .rf_dat(rf_dat), .prod_valid(pv), .prod_reg(prod_reg),
    .prod_data(prod_data), .prod_is_load(pl), .prod_ready(pr),
    .opnd(opnd_s), .stall(stall_s), .bubble(bubble_s), .state_o(state_s), .stall_cnt(cnt_s)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ex_valid = 1'b1; ext_stall = 1'b0;
    pv = '0; pl = '0; pr = '0;
    for (int i = 0; i < NREAD; i++) begin sreg[i] = '0; rf[i] = 32'h1111 * (i + 1); end
    for (int k = 0; k < NSTAGES; k++) begin preg[k] = '0; pdat[k] = '0; end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  // Port 1 waits on an unready stage-0 load of r3 while stage 1 carries r7 for port 0.
  task automatic hold_setup();
    idle();
    sreg[0] = 5'd7; sreg[1] = 5'd3;
    pv = 2'b11; pl = 2'b01; pr = 2'b00;
    preg[0] = 5'd3; pdat[0] = 32'hD00D;
    preg[1] = 5'd7; pdat[1] = 32'hCAFE;
  endtask

  initial begin
    RST = 1'b1;
    idle();
    step();
    chk("rst_state", state_o, 0);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_stall", stall, 0);
    RST = 1'b0;

    // forwarding priority
    pv = 2'b11; preg[0] = 5'd5; preg[1] = 5'd5;
    pdat[0] = 32'hAAAA; pdat[1] = 32'hBBBB; sreg[0] = 5'd5;
    #1;
    chk("prio_young", opnd[31:0], 32'hAAAA);
    chk("prio_nostall", stall, 0);
    pv = 2'b10;
    #1;
    chk("prio_old", opnd[31:0], 32'hBBBB);

    // r0 guard
    pv = 2'b01; preg[0] = 5'd0; pdat[0] = 32'h1234; sreg[1] = 5'd0;
    #1;
    chk("r0_opnd1", opnd[63:32], 0);
    chk("r0_stall", stall, 0);
    chk("r0_opnd0_rf", opnd[31:0], 32'h1111);
    step();

    // load-use for 3 cycles
    do_reset();
    idle();
    pv = 2'b01; pl = 2'b01; preg[0] = 5'd3; pdat[0] = 32'hD00D; sreg[0] = 5'd3;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("lu_stall", stall, 1);
      chk("lu_bubble", bubble, 1);
      chk("lu_opnd_rf", opnd[31:0], 32'h1111);
      step();
      chk("lu_state", state_o, 1);
      chk("lu_cnt", stall_cnt, c + 1);
    end
    pr = 2'b01;
    #1;
    chk("lu_ready_opnd", opnd[31:0], 32'hD00D);
    chk("lu_ready_stall", stall, 0);
    chk("lu_ready_state", state_o, 1);
    step();
    chk("lu_back_run", state_o, 0);
    chk("lu_cnt_final", stall_cnt, 3);

    // ext_stall overlapping a hazard
    pr = 2'b00; ext_stall = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("ext_stall", stall, 1);
      chk("ext_bubble", bubble, 0);
      step();
      chk("ext_cnt", stall_cnt, 3);
    end
    ext_stall = 1'b0; pr = 2'b01;
    step();

    // hold across stall
    do_reset();
    hold_setup();
    #1;
    chk("hold_stall", stall, 1);
    chk("hold_fwd", opnd[31:0], 32'hCAFE);
    chk("hold_p1_rf", opnd[63:32], 32'h2222);
    step();
    pv = 2'b01;
    #1;
    chk("hold_after_retire", opnd[31:0], 32'hCAFE);
    chk("hold_still_stall", stall, 1);
    step();
    chk("hold_2nd_cycle", opnd[31:0], 32'hCAFE);
    pr = 2'b01;
    #1;
    chk("hold_release_stall", stall, 0);
    chk("hold_p1_fwd", opnd[63:32], 32'hD00D);
    chk("hold_release_opnd", opnd[31:0], 32'hCAFE);
    step();
    pv = 2'b00;
    #1;
    chk("hold_cleared", opnd[31:0], 32'h1111);

    // reset while waiting with a live hold
    do_reset();
    hold_setup();
    step();
    pv = 2'b01;
    #1;
    chk("rw_state_pre", state_o, 1);
    chk("rw_hold_pre", opnd[31:0], 32'hCAFE);
    RST = 1'b1;
    step();
    chk("rw_state", state_o, 0);
    chk("rw_cnt", stall_cnt, 0);
    chk("rw_opnd", opnd[31:0], 32'h1111);
    chk("rw_stall_in_rst", stall, 0);
    RST = 1'b0;
    #1;
    chk("rw_stall_after", stall, 1);

    // saturation
    do_reset();
    idle();
    chk("sat_cnt0", cnt_s, 0);
    pv = 2'b01; pl = 2'b01; preg[0] = 5'd3; sreg[0] = 5'd3;
    repeat (20) step();
    chk("sat_cnt16", stall_cnt, 20);
    chk("sat_cnt4", cnt_s, 15);
    ex_valid = 1'b0;
    #1;
    chk("noval_stall", stall, 0);
    step();
    chk("noval_cnt", stall_cnt, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
